// File: rtl/mmio_master_if.sv
// MMIO master interface: CPU request/response handshake plus MMIO bus.
// Modport master is the mmio_master side; slave is the CPU/responder side.
interface mmio_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mmio_o_addr;
    logic [3:0]  mmio_o_wmask;
    logic [31:0] mmio_o_wdata;
    logic [31:0] mmio_i_rdata;

    modport master (
        input  req_valid, req_we, req_funct3,
        input  req_addr, req_wdata, mmio_i_rdata,
        output req_ready, resp_valid, resp_rdata,
        output resp_fault, mmio_o_addr,
        output mmio_o_wmask, mmio_o_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3,
        output req_addr, req_wdata, mmio_i_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  resp_fault, mmio_o_addr,
        input  mmio_o_wmask, mmio_o_wdata
    );
endinterface

// File: rtl/mmio_master.sv
// MMIO bus initiator: one load/store at a time, word-aligned bus cycle,
// lane masks/replication, read extract/extend, misalign/illegal faults.
// Ports: clk, rst (sync, active-high), bus (mmio_master_if.master).
module mmio_master #(
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mmio_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    // Counter preload; RD_LAT=0 never enters WAIT.
    localparam logic [1:0] LAT_M1 =
        (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_fault_q, resp_fault_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;

    function automatic logic is_fault(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic f;
        f = 1'b1;
        case (f3)
            3'b000: f = 1'b0;
            3'b001: f = lo[0];
            3'b010: f = |lo;
            3'b100: f = we;
            3'b101: f = we | lo[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] lane_mask(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic [3:0] m;
        m = 4'b1111;
        case (f3[1:0])
            2'b00: m = 4'b0001 << lo;
            2'b01: m = 4'b0011 << {lo[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(
        input logic [2:0]  f3,
        input logic [31:0] wd
    );
        logic [31:0] d;
        d = wd;
        case (f3[1:0])
            2'b00: d = {4{wd[7:0]}};
            2'b01: d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] extract(
        input logic [31:0] rd,
        input logic [2:0]  f3,
        input logic [1:0]  lo
    );
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh = rd >> {lo, 3'b000};
        b  = sh[7:0];
        h  = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000: r = {{24{b[7]}}, b};
            3'b100: r = {24'd0, b};
            3'b001: r = {{16{h[15]}}, h};
            3'b101: r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        f3_d         = f3_q;
        lo_d         = lo_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        // Strobes and response payload are single-cycle.
        wmask_d      = 4'd0;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rdata_d = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d = bus.req_we;
                    f3_d = bus.req_funct3;
                    lo_d = bus.req_addr[1:0];
                    if (is_fault(bus.req_we, bus.req_funct3,
                                 bus.req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        addr_d  = {bus.req_addr[31:2], 2'b00};
                        wdata_d = lane_data(bus.req_funct3,
                                            bus.req_wdata);
                        if (bus.req_we) begin
                            wmask_d = lane_mask(bus.req_funct3,
                                                bus.req_addr[1:0]);
                        end
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else if (RD_LAT == 0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = extract(bus.mmio_i_rdata,
                                           f3_q, lo_q);
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = extract(bus.mmio_i_rdata,
                                           f3_q, lo_q);
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            we_q         <= 1'b0;
            f3_q         <= 3'd0;
            lo_q         <= 2'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wmask_q      <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            lo_q         <= lo_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Ready is gated by rst so it is low during the reset cycle.
    assign bus.req_ready    = (state_q == IDLE) && !rst;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_fault   = resp_fault_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.mmio_o_addr  = addr_q;
    assign bus.mmio_o_wmask = wmask_q;
    assign bus.mmio_o_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_master.sv
// Bench for mmio_master: three instances with RD_LAT 0/1/2,
// latency-exact responder, response scoreboard.
module tb_mmio_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compares = 0;
    int fails = 0;

    logic [2:0]  req_valid = '0;
    logic [2:0]  req_we = '0;
    logic [2:0]  req_funct3 [3];
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic [2:0]  req_ready;
    logic [2:0]  resp_valid;
    logic [2:0]  resp_fault;
    logic [31:0] resp_rdata [3];
    logic [31:0] mmio_o_addr [3];
    logic [31:0] mmio_o_wdata [3];
    logic [3:0]  mmio_o_wmask [3];
    logic [31:0] rd_word = 32'h80FF7F01;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   wm_cyc[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mmio_master_if bus ();
        logic       issue_now = 1'b0;
        logic [1:0] hist = '0;
        logic [2:0] pipe;

        assign bus.req_valid  = req_valid[g];
        assign bus.req_we     = req_we[g];
        assign bus.req_funct3 = req_funct3[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign req_ready[g]   = bus.req_ready;
        assign resp_valid[g]  = bus.resp_valid;
        assign resp_fault[g]  = bus.resp_fault;
        assign resp_rdata[g]  = bus.resp_rdata;
        assign mmio_o_addr[g] = bus.mmio_o_addr;
        assign mmio_o_wdata[g] = bus.mmio_o_wdata;
        assign mmio_o_wmask[g] = bus.mmio_o_wmask;

        // Responder: data valid only exactly RD_LAT cycles
        // after the ISSUE cycle begins, garbage otherwise.
        always @(posedge clk) begin
            issue_now <= req_valid[g] & req_ready[g];
            hist      <= {hist[0], issue_now};
        end
        assign pipe = {hist, issue_now};
        assign bus.mmio_i_rdata =
            pipe[g] ? rd_word : 32'h5A5AC3C3;

        mmio_master #(.RD_LAT(g)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (resp_valid[g] === 1'b1) begin
                compares++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_resp observed=%0d expected=none",
                           g);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_inst", 32'(g), 32'(e.inst));
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("resp_rdata", resp_rdata[g], e.rdata);
                    chk("resp_fault", 32'(resp_fault[g]),
                        32'(e.fault));
                end
            end
        end
        if (mmio_o_wmask[0] != 4'd0) wm_cyc.push_back(cyc);
    end

    // Called at a negedge; returns at the negedge of cycle 2.
    task automatic access(input int          inst,
                          input bit          we,
                          input logic [2:0]  f3,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [31:0] e_rdata,
                          input bit          e_fault,
                          input logic [3:0]  e_mask,
                          input logic [31:0] e_wdata,
                          input bit          keep);
        int   n;
        int   t;
        exp_t e;
        n = e_fault ? 1 : (we ? 2 : 2 + inst);
        req_we[inst]     = we;
        req_funct3[inst] = f3;
        req_addr[inst]   = a;
        req_wdata[inst]  = wd;
        req_valid[inst]  = 1'b1;
        t = 0;
        while (req_ready[inst] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 32'(req_ready[inst]), 32'd1);
        e.inst  = inst;
        e.cyc   = cyc + n;
        e.rdata = e_rdata;
        e.fault = e_fault;
        sb.push_back(e);
        @(negedge clk);
        if (!keep) req_valid[inst] = 1'b0;
        chk("wmask_c1", 32'(mmio_o_wmask[inst]),
            32'(e_fault ? 4'd0 : e_mask));
        if (!e_fault) begin
            chk("addr_c1", mmio_o_addr[inst],
                a & 32'hFFFFFFFC);
            if (we) chk("wdata_c1", mmio_o_wdata[inst], e_wdata);
        end
        @(negedge clk);
        chk("wmask_c2", 32'(mmio_o_wmask[inst]), 32'd0);
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && sb.size() != 0; t++)
            @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            req_funct3[g] = 3'd0;
            req_addr[g]   = 32'd0;
            req_wdata[g]  = 32'd0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("rst_valid", 32'(resp_valid[g]), 32'd0);
            chk("rst_rdata", resp_rdata[g], 32'd0);
            chk("rst_addr", mmio_o_addr[g], 32'd0);
            chk("rst_wmask", 32'(mmio_o_wmask[g]), 32'd0);
            chk("rst_wdata", mmio_o_wdata[g], 32'd0);
        end
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd7);

        // Stores
        access(1, 1, 3'b010, 32'h4, 32'hDEADBEEF,
               32'd0, 0, 4'b1111, 32'hDEADBEEF, 0);
        drain();
        access(1, 1, 3'b000, 32'h6, 32'h000000A5,
               32'd0, 0, 4'b0100, 32'hA5A5A5A5, 0);
        drain();
        access(1, 1, 3'b001, 32'h6, 32'h00001234,
               32'd0, 0, 4'b1100, 32'h12341234, 0);
        drain();

        // Loads at each read latency
        for (int g = 0; g < 3; g++) begin
            access(g, 0, 3'b000, 32'h3, 32'd0,
                   32'hFFFFFF80, 0, 4'd0, 32'd0, 0);
            drain();
            access(g, 0, 3'b100, 32'h3, 32'd0,
                   32'h00000080, 0, 4'd0, 32'd0, 0);
            drain();
            access(g, 0, 3'b001, 32'h2, 32'd0,
                   32'hFFFF80FF, 0, 4'd0, 32'd0, 0);
            drain();
            access(g, 0, 3'b101, 32'h0, 32'd0,
                   32'h00007F01, 0, 4'd0, 32'd0, 0);
            drain();
            access(g, 0, 3'b010, 32'h0, 32'd0,
                   32'h80FF7F01, 0, 4'd0, 32'd0, 0);
            drain();
        end

        // Faults
        access(1, 0, 3'b010, 32'h2, 32'd0,
               32'd0, 1, 4'd0, 32'd0, 0);
        drain();
        access(1, 1, 3'b001, 32'h1, 32'h5555,
               32'd0, 1, 4'd0, 32'd0, 0);
        drain();
        access(1, 1, 3'b100, 32'h0, 32'h77,
               32'd0, 1, 4'd0, 32'd0, 0);
        drain();
        access(1, 0, 3'b011, 32'h0, 32'd0,
               32'd0, 1, 4'd0, 32'd0, 0);
        drain();

        // Back-to-back stores with req_valid held
        wm_cyc.delete();
        access(0, 1, 3'b010, 32'h10, 32'h11111111,
               32'd0, 0, 4'b1111, 32'h11111111, 1);
        access(0, 1, 3'b000, 32'h11, 32'h00000022,
               32'd0, 0, 4'b0010, 32'h22222222, 1);
        access(0, 1, 3'b001, 32'h12, 32'h00003333,
               32'd0, 0, 4'b1100, 32'h33333333, 0);
        drain();
        chk("b2b_pulses", 32'(wm_cyc.size()), 32'd3);
        if (wm_cyc.size() == 3) begin
            chk("b2b_gap0", 32'(wm_cyc[1] - wm_cyc[0]), 32'd3);
            chk("b2b_gap1", 32'(wm_cyc[2] - wm_cyc[1]), 32'd3);
        end

        // Reset during WAIT (RD_LAT=2)
        req_we[2]     = 1'b0;
        req_funct3[2] = 3'b010;
        req_addr[2]   = 32'h8;
        req_wdata[2]  = 32'h11111111;
        req_valid[2]  = 1'b1;
        chk("wr_ready", 32'(req_ready[2]), 32'd1);
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("wr_addr", mmio_o_addr[2], 32'h8);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("wr_ready_rst", 32'(req_ready[2]), 32'd0);
        chk("wr_valid", 32'(resp_valid[2]), 32'd0);
        chk("wr_addr0", mmio_o_addr[2], 32'd0);
        chk("wr_wdata0", mmio_o_wdata[2], 32'd0);
        chk("wr_wmask0", 32'(mmio_o_wmask[2]), 32'd0);
        chk("wr_rdata0", resp_rdata[2], 32'd0);
        chk("wr_fault0", 32'(resp_fault[2]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("wr_idle", 32'(req_ready[2]), 32'd1);
        repeat (4) @(negedge clk);
        access(2, 0, 3'b010, 32'h0, 32'd0,
               32'h80FF7F01, 0, 4'd0, 32'd0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compares, fails);
        $finish;
    end

endmodule

// File: doc/mmio_master.md
# mmio_master

Bus initiator for the core's memory-mapped I/O port. Accepts one load or store request at a time from the CPU load/store stage and converts it into a word-aligned MMIO bus cycle: byte-lane write mask, lane-replicated write data, and aligned, sign- or zero-extended read data. Detects misaligned and illegal accesses and faults them without touching the bus. Sits between the execute/memory pipeline stage and the MMIO address decoder (GPIO IDR/ODR and later peripherals).

## Interface
- RD_LAT, default 1: read latency of the responder in cycles, legal values 0..2. Read data is valid RD_LAT cycles after the address is presented; 0 means combinational read.
- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response strobe; no backpressure
- resp_rdata  out  32  load result, extended; 0 for stores and faults
- resp_fault  out  1  misaligned or illegal access; qualified by resp_valid
- mmio_o_addr  out  32  word-aligned bus address, i.e. req_addr with bits [1:0] cleared
- mmio_o_wmask  out  4  byte-lane write enables; nonzero only in the ISSUE cycle of a store
- mmio_o_wdata  out  32  lane-replicated store data
- mmio_i_rdata  in  32  responder read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: req_ready=1. If req_valid=1 at the edge, latch the request.
  - Legal access: go to ISSUE. Load mmio_o_addr, mmio_o_wdata, and mmio_o_wmask (stores only) at the same edge.
  - Fault: go directly to RESP with fault=1. Bus outputs are unchanged and wmask stays 0.
- Fault conditions:
  - funct3 is 011, 110 or 111.
  - Store with funct3 100 or 101.
  - H/HU access with addr[0]=1.
  - W access with addr[1:0]≠0.
- ISSUE (exactly 1 cycle):
  - Store: next state RESP.
  - Load with RD_LAT=0: capture mmio_i_rdata at this edge, then go to RESP.
  - Load with RD_LAT>0: go to WAIT and load the counter with RD_LAT-1.
- WAIT: mmio_o_addr held, wmask=0. When the counter reaches 0, capture mmio_i_rdata at that edge and go to RESP. Otherwise decrement.
- RESP: resp_valid=1 for one cycle, then go to IDLE.
- Write mask:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1],1'b0}.
  - SW: 4'b1111.
- Write data: SB replicates wdata[7:0] ×4, SH replicates wdata[15:0] ×2, SW passes wdata through.
- Read extract:
  - Bytes: lane = rdata >> (8·addr[1:0]); take [7:0].
  - Halves: take [15:0] at lane addr[1].
  - Extension: B/H sign-extend; BU/HU zero-extend; W passes through.
- Reset values: req_ready=0 during the reset cycle. After reset: resp_valid=0, resp_rdata=0, resp_fault=0, mmio_o_addr=0, mmio_o_wmask=0, mmio_o_wdata=0, state IDLE.

## Timing
- All outputs are registered except req_ready, which is decoded from state.
- Load latency, measured from the accept edge to the edge after the resp_valid cycle: resp_valid is high in cycle 2+RD_LAT after acceptance. Store: cycle 2. Fault: cycle 1.
- Throughput: one access per 3+RD_LAT cycles (load), 3 cycles (store), 2 cycles (fault).
- mmio_o_wmask is high for exactly one cycle per store. The responder commits at the edge ending ISSUE.
- mmio_o_addr and mmio_o_wdata hold their last value outside transactions.
- req_valid while not in IDLE is ignored and not latched. The requester must hold the request until it sees req_ready.
- rst in any state: at that edge go to IDLE and clear all outputs. No response is issued for the aborted access.
- If rst is high during a store's ISSUE cycle, the write outcome is defined by the responder's reset priority. No resp_valid is issued.

## Test plan
- Reset, then SW addr=0x4, data=0xDEADBEEF: wmask=1111 for 1 cycle, wdata=0xDEADBEEF, addr=0x4. resp_valid in cycle 2 with fault=0, rdata=0.
- SB addr=0x6, data=0x000000A5: wmask=0100, wdata=0xA5A5A5A5, addr=0x4. SH addr=0x6, data=0x1234: wmask=1100, wdata=0x12341234.
- Responder returns 0x80FF7F01 with RD_LAT=0/1/2:
  - LB addr 0x3 → 0xFFFFFF80.
  - LBU addr 0x3 → 0x00000080.
  - LH addr 0x2 → 0xFFFF80FF.
  - LHU addr 0x0 → 0x00007F01.
  - LW addr 0x0 → 0x80FF7F01.
  - resp_valid arrives at cycle 2+RD_LAT in every case.
- Faults:
  - LW addr 0x2, SH addr 0x1, SB funct3=100 and funct3=011 each give resp_valid in cycle 1 with fault=1, rdata=0.
  - wmask is never nonzero during these.
- Back-to-back: req_valid held high with 3 stores. Exactly 3 one-cycle wmask pulses, 3 cycles apart. Requests presented while busy are not accepted.
- rst asserted in WAIT (RD_LAT=2): at the next edge state=IDLE, all outputs 0, no resp_valid. The next request then completes normally.
